// File: rtl/tick_countdown.sv
// Tick-driven countdown with an edge-detecting tick_in synchronizer, 4-state FSM and BCD display digits.
// tick_pulse lags tick_in by SYNC_STAGES+1 cycles; no backpressure. TICK_BOTH_EDGES_EN counts both tick_in edges.
module tick_countdown #(
    parameter int LOAD_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              tick_in,
    input  logic              start,
    input  logic              pause,
    input  logic [LOAD_W-1:0] load_value,
    output logic              tick_pulse,
    output logic [LOAD_W-1:0] remaining,
    output logic              running,
    output logic              expired,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   edge_det;
    logic [1:0]             state_q;
    int                     rem_int;

    // prime_q keeps the freshly-cleared chain from faking an edge when tick_in is already high after reset
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            prime_q    <= '0;
            tick_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
            hist_q     <= sync_q[SYNC_STAGES-1];
            prime_q    <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            tick_pulse <= edge_det;
        end
    end

`ifdef TICK_BOTH_EDGES_EN
    assign edge_det = prime_q[SYNC_STAGES] & (sync_q[SYNC_STAGES-1] ^ hist_q);
`else
    assign edge_det = prime_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~hist_q;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            remaining <= '0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (start) begin
                if (load_value != '0) begin
                    state_q   <= ST_RUN;
                    remaining <= load_value;
                end else begin
                    state_q   <= ST_EXPIRED;
                    remaining <= '0;
                    expired   <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (pause) begin
                            state_q <= ST_PAUSED;
                        end else if (tick_pulse) begin
                            if (remaining <= LOAD_W'(1)) begin
                                remaining <= '0;
                                state_q   <= ST_EXPIRED;
                                expired   <= 1'b1;
                            end else begin
                                remaining <= remaining - LOAD_W'(1);
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) state_q <= ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign running = (state_q == ST_RUN) || (state_q == ST_PAUSED);

    always_comb begin
        rem_int  = int'(remaining);
        bcd_tens = 4'd9;
        bcd_ones = 4'd9;
        if (rem_int <= 99) begin
            bcd_tens = 4'(rem_int / 10);
            bcd_ones = 4'(rem_int % 10);
        end
    end

endmodule

// File: tb/tb_tick_countdown.sv
// Directed bench for tick_countdown; default build checks rising-edge-only behaviour, the macro build both edges.
module tb_tick_countdown;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic [6:0] load_value;
    logic       tick_pulse;
    logic [6:0] remaining;
    logic       running;
    logic       expired;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

`ifdef TICK_BOTH_EDGES_EN
    localparam int FC = 1;
`else
    localparam int FC = 0;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int pulse_cnt = 0;
    int e0;
    int p0;

    tick_countdown #(.LOAD_W(7), .SYNC_STAGES(2)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .tick_in    (tick_in),
        .start      (start),
        .pause      (pause),
        .load_value (load_value),
        .tick_pulse (tick_pulse),
        .remaining  (remaining),
        .running    (running),
        .expired    (expired),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (expired === 1'b1)    exp_cnt   <= exp_cnt + 1;
        if (tick_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_start(input logic [6:0] v);
        @(negedge clk_in);
        start = 1'b1;
        load_value = v;
        @(posedge clk_in);
        #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk_in);
        tick_in = 1'b1;
        cyc(6);
        @(negedge clk_in);
        tick_in = 1'b0;
        cyc(6);
    endtask

    initial begin
        reset = 1'b1;
        tick_in = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        load_value = '0;
        cyc(3);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_pulse", 32'(tick_pulse), 0);
        chk("rst_tens", 32'(bcd_tens), 0);
        chk("rst_ones", 32'(bcd_ones), 0);
        @(negedge clk_in);
        reset = 1'b0;
        cyc(4);

`ifndef TICK_BOTH_EDGES_EN
        // basic countdown with latency and falling-edge checks on the last tick
        e0 = exp_cnt;
        do_start(7'd3);
        chk("basic_load", 32'(remaining), 3);
        chk("basic_running", 32'(running), 1);
        tick();
        chk("basic_rem2", 32'(remaining), 2);
        tick();
        chk("basic_rem1", 32'(remaining), 1);
        @(negedge clk_in);
        tick_in = 1'b1;
        @(posedge clk_in);
        cyc(1);
        chk("lat_cycle2_low", 32'(tick_pulse), 0);
        cyc(1);
        chk("lat_cycle3_high", 32'(tick_pulse), 1);
        chk("lat_rem_before", 32'(remaining), 1);
        cyc(1);
        chk("lat_one_cycle", 32'(tick_pulse), 0);
        chk("basic_rem0", 32'(remaining), 0);
        chk("basic_expired", 32'(expired), 1);
        chk("basic_run_fall", 32'(running), 0);
        cyc(1);
        chk("basic_expired_done", 32'(expired), 0);
        p0 = pulse_cnt;
        @(negedge clk_in);
        tick_in = 1'b0;
        cyc(8);
        chk("fall_no_pulse", 32'(pulse_cnt), 32'(p0));
        chk("basic_exp_count", 32'(exp_cnt - e0), 1);
        chk("expired_hold", 32'(remaining), 0);

        // pause holds the count while ticks keep arriving
        e0 = exp_cnt;
        do_start(7'd5);
        tick();
        chk("pause_rem4", 32'(remaining), 4);
        @(negedge clk_in);
        pause = 1'b1;
        repeat (4) tick();
        chk("pause_hold", 32'(remaining), 4);
        chk("pause_running", 32'(running), 1);
        @(negedge clk_in);
        pause = 1'b0;
        cyc(1);
        repeat (4) tick();
        chk("pause_end_rem", 32'(remaining), 0);
        chk("pause_exp_count", 32'(exp_cnt - e0), 1);
        chk("pause_end_run", 32'(running), 0);

        // start colliding with tick_pulse reloads without decrement
        do_start(7'd3);
        tick();
        chk("coll_rem2", 32'(remaining), 2);
        @(negedge clk_in);
        tick_in = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        cyc(1);
        chk("coll_pulse", 32'(tick_pulse), 1);
        @(negedge clk_in);
        start = 1'b1;
        load_value = 7'd9;
        cyc(1);
        start = 1'b0;
        chk("coll_reload", 32'(remaining), 9);
        chk("coll_running", 32'(running), 1);
        @(negedge clk_in);
        tick_in = 1'b0;
        cyc(8);
        chk("coll_no_dec", 32'(remaining), 9);
        @(negedge clk_in);
        start = 1'b1;
        load_value = 7'd0;
        cyc(1);
        start = 1'b0;
        chk("zero_rem", 32'(remaining), 0);
        chk("zero_expired", 32'(expired), 1);
        chk("zero_running", 32'(running), 0);
        e0 = exp_cnt;
        cyc(5);
        chk("zero_no_repeat", 32'(exp_cnt), 32'(e0 + 1));
        chk("zero_exp_low", 32'(expired), 0);

        // BCD digits
        do_start(7'd120);
        chk("bcd120_tens", 32'(bcd_tens), 9);
        chk("bcd120_ones", 32'(bcd_ones), 9);
        do_start(7'd57);
        chk("bcd57_tens", 32'(bcd_tens), 5);
        chk("bcd57_ones", 32'(bcd_ones), 7);
        do_start(7'd100);
        chk("bcd100_tens", 32'(bcd_tens), 9);
        chk("bcd100_ones", 32'(bcd_ones), 9);
        do_start(7'd9);
        chk("bcd9_tens", 32'(bcd_tens), 0);
        chk("bcd9_ones", 32'(bcd_ones), 9);
`else
        // both edges: two counts per tick_in period
        e0 = exp_cnt;
        do_start(7'd4);
        tick();
        chk("both_rem2", 32'(remaining), 2);
        tick();
        chk("both_rem0", 32'(remaining), 0);
        chk("both_exp_count", 32'(exp_cnt - e0), 1);
        chk("both_running", 32'(running), 0);
        do_start(7'd9);
        @(negedge clk_in);
        tick_in = 1'b1;
        cyc(6);
        chk("both_rise_dec", 32'(remaining), 8);
        @(negedge clk_in);
        tick_in = 1'b0;
        @(posedge clk_in);
        cyc(1);
        chk("both_fall_cycle2_low", 32'(tick_pulse), 0);
        cyc(1);
        chk("both_fall_cycle3_high", 32'(tick_pulse), 1);
        chk("both_fall_rem_before", 32'(remaining), 8);
        cyc(1);
        chk("both_fall_one_cycle", 32'(tick_pulse), 0);
        chk("both_fall_dec", 32'(remaining), 7);
        do_start(7'd120);
        chk("both_bcd_tens", 32'(bcd_tens), 9);
        chk("both_bcd_ones", 32'(bcd_ones), 9);
`endif

        // reset mid-run, overriding start, with tick_in high through reset
        do_start(7'd10);
        repeat (4) tick();
        chk("mid_rem", 32'(remaining), 32'(10 - 4 * (1 + FC)));
        e0 = exp_cnt;
        @(negedge clk_in);
        reset = 1'b1;
        start = 1'b1;
        load_value = 7'd5;
        tick_in = 1'b1;
        cyc(2);
        @(negedge clk_in);
        reset = 1'b0;
        start = 1'b0;
        cyc(1);
        chk("mid_rst_rem", 32'(remaining), 0);
        chk("mid_rst_running", 32'(running), 0);
        chk("mid_rst_expired", 32'(expired), 0);
        chk("mid_rst_pulse", 32'(tick_pulse), 0);
        p0 = pulse_cnt;
        cyc(10);
        chk("post_rst_no_pulse", 32'(pulse_cnt), 32'(p0));
        chk("post_rst_no_expired", 32'(exp_cnt), 32'(e0));
        @(negedge clk_in);
        tick_in = 1'b0;
        cyc(6);
        @(negedge clk_in);
        tick_in = 1'b1;
        cyc(6);
        chk("post_rst_fresh_edge", 32'(pulse_cnt), 32'(p0 + 1 + FC));
        chk("idle_ignores_ticks", 32'(remaining), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_countdown.md
TICK_COUNTDOWN -- requirements
Module: tick_countdown

Interface
REQ-001 The block SHALL expose parameter LOAD_W, default 7, giving the width of load_value and remaining.
REQ-002 The block SHALL expose parameter SYNC_STAGES, default 2 (minimum 2), giving the number of tick_in synchronizer flops.
REQ-003 clk_in  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick_in  input  1  slow square wave from the difficulty clock divider; asynchronous to clk_in.
REQ-006 start  input  1  single-cycle request to load load_value and begin the countdown.
REQ-007 pause  input  1  level; while high, the countdown SHALL hold.
REQ-008 load_value  input  LOAD_W  initial tick count, sampled only in the cycle start is high.
REQ-009 tick_pulse  output  1  one-cycle strobe for each detected tick_in edge.
REQ-010 remaining  output  LOAD_W  registered count of ticks left.
REQ-011 running  output  1  high in RUN and PAUSED.
REQ-012 expired  output  1  one-cycle strobe when the countdown reaches 0.
REQ-013 bcd_tens, bcd_ones  output  4 each  decimal display digits of remaining.

Function
REQ-014 tick_in SHALL pass through SYNC_STAGES flops, followed by one history flop for edge detection.
REQ-015 With SYNC_STAGES=2, tick_pulse SHALL be registered and high for exactly one cycle, 3 clk_in cycles after the first edge that samples the new tick_in level.
REQ-016 tick_pulse SHALL be generated in every state, independent of pause.
REQ-017 The FSM SHALL have four states: IDLE, RUN, PAUSED, EXPIRED; the encoding is implementation-defined.
REQ-018 start with load_value!=0 SHALL move the FSM to RUN and load remaining, from any state; start is accepted in RUN and PAUSED and restarts the countdown.
REQ-019 start with load_value==0 SHALL move the FSM to EXPIRED, set remaining=0, and pulse expired in the next cycle.
REQ-020 In RUN, tick_pulse=1 with pause=0 SHALL decrement remaining by 1.
REQ-021 When remaining==1 is decremented, remaining SHALL become 0, the FSM SHALL enter EXPIRED, and expired SHALL be high in that same cycle.
REQ-022 In RUN, pause=1 SHALL move the FSM to PAUSED on the next edge.
REQ-023 A tick_pulse in the same cycle as pause=1 in RUN SHALL be ignored.
REQ-024 In PAUSED, ticks SHALL be ignored, and pause=0 SHALL return the FSM to RUN.
REQ-025 start in the same cycle as tick_pulse SHALL take priority: reload with no decrement.
REQ-026 remaining SHALL never wrap below 0.
REQ-027 EXPIRED SHALL hold remaining=0 until start is received; expired SHALL not repeat.
REQ-028 bcd_tens/bcd_ones SHALL be combinational from remaining, showing remaining mod 100 split into tens and ones when remaining<=99, and saturating at 9/9 when remaining>99.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE, and remaining, tick_pulse, running, expired and all synchronizer/history flops SHALL clear to 0.
REQ-030 Reset mid-countdown SHALL abort with no expired pulse.
REQ-031 Reset SHALL override start in the same cycle.
REQ-032 The first tick_pulse after reset SHALL require a fresh qualifying tick_in edge.

Configuration
REQ-033 The macro TICK_BOTH_EDGES_EN SHALL select which tick_in edges are detected.
REQ-034 With TICK_BOTH_EDGES_EN defined, both rising and falling synchronized tick_in edges SHALL generate tick_pulse, giving 2 counts per tick_in period.
REQ-035 With TICK_BOTH_EDGES_EN undefined, only rising edges SHALL generate tick_pulse.
REQ-036 The latency in REQ-015 SHALL be the same in both configurations.

Verification
REQ-037 Basic countdown: reset, start with load_value=3, then 3 rising tick_in edges -> remaining goes 3,2,1,0; expired is high for 1 cycle together with remaining=0; running then falls.
REQ-038 Latency: tick_in rises at a known edge -> tick_pulse is high exactly on the 3rd following cycle, for 1 cycle; with the macro undefined, a falling tick_in edge produces no pulse.
REQ-039 Pause: load 5, 1 tick, pause=1, 4 ticks, pause=0, 4 ticks -> remaining holds 4 during the pause, then reaches 0 with 1 expired pulse.
REQ-040 Collisions: start (load_value=9) in the same cycle as tick_pulse while remaining=2 -> remaining=9 with no decrement; start with load_value=0 -> expired next cycle, remaining=0.
REQ-041 Reset mid-run: load 10, 4 ticks, assert reset -> all outputs 0, no expired pulse, IDLE, running=0.
REQ-042 BCD and TICK_BOTH_EDGES_EN: load 120 -> digits 9/9; with TICK_BOTH_EDGES_EN, load 4 and apply 2 tick_in periods -> remaining=0 and expired pulses.
